pc_next_unit: RTL

Program-counter stage sitting directly downstream of the branch comparator. Consumes `brEq`/`brLt` together with the decoded control-transfer type and selects the next PC. Holds the architectural PC register and drives the instruction-fetch address. Sequences boot, stall and misaligned-target trap behaviour.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/branch_cond.sv | 27 ++
 rtl/pc_next_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch funct3 encodings, PC FSM states and default vectors.
package cpu_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/branch_cond.sv
// Branch condition decode from funct3 and the comparator's brEq/brLt flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       brEq,
    input  logic       brLt,
    output logic       cond
);

    logic lt_true;

    // The comparator asserts brLt when rs1 > operand B, so "less than" is neither greater nor equal.
    assign lt_true = ~brLt & ~brEq;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:          cond = brEq;
            F3_BNE:          cond = ~brEq;
            F3_BLT, F3_BLTU: cond = lt_true;
            F3_BGE, F3_BGEU: cond = brLt | brEq;
            default:         cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC selection, PC register and BOOT/RUN/TRAP sequencing.
// Optional branch statistics counters are built when PC_NEXT_BR_STATS_EN is defined.
module pc_next_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic        isBranch,
    input  logic        isJal,
    input  logic        isJalr,
    input  logic [2:0]  funct3,
    input  logic        brEq,
    input  logic        brLt,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        imem_req,
    output logic        taken,
    output logic        trap,
`ifdef PC_NEXT_BR_STATS_EN
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt,
`endif
    output logic [1:0]  state_dbg_o
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target;
    logic        cond;
    logic        advance;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .brEq   (brEq),
        .brLt   (brLt),
        .cond   (cond)
    );

    // JALR wins over JAL/branch; both of the latter use the pc-relative target.
    assign target  = isJalr ? ((rs1 + imm) & ~32'h1) : (pc_q + imm);
    assign taken   = instr_valid & (isJal | isJalr | (isBranch & cond));
    assign pcPlus4 = pc_q + 32'd4;
    assign advance = (state_q == RUN) & instr_valid & ~stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (advance) begin
                    if (taken && target[1]) begin
                        pc_d    = TRAP_VEC;
                        state_d = TRAP;
                    end else if (taken) begin
                        pc_d = target;
                    end else begin
                        pc_d = pcPlus4;
                    end
                end
            end
            TRAP: if (!stall) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc          = pc_q;
    assign imem_req    = (state_q == RUN);
    assign trap        = (state_q == TRAP);
    assign state_dbg_o = state_q;

`ifdef PC_NEXT_BR_STATS_EN
    logic [31:0] br_cnt_q, taken_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else if (advance) begin
            if (isBranch && br_cnt_q != 32'hFFFF_FFFF)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (taken && taken_cnt_q != 32'hFFFF_FFFF)
                taken_cnt_q <= taken_cnt_q + 32'd1;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

endmodule
